// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU, host/debug),
// the arbiter, and the single-port data RAM.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever surrounds it: the requesters and the RAM read path.
interface dm_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // CPU port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Host / debug port
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    // RAM side; mem_rd also serves as the RAM output enable
    logic              mem_cs;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_cs, mem_rd, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_cs, mem_rd, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU and host share one single-port RAM.
// Each granted access takes one cycle. Ties go to the port that was not
// served last. Read data is registered per port and returned the cycle
// after the access.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | RAM deselected; picks the next owner from the pending reqs
//  CPU_ACC  | CPU owns the RAM for this cycle (cpu_gnt=1)
//  HOST_ACC | host owns the RAM for this cycle (host_gnt=1)
module dm_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        clr,
    dm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        HOST_ACC = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    state_t            state_q;
    state_t            state_d;
    owner_t            last_owner_q;

    logic              cpu_gnt;
    logic              host_gnt;
    logic              mem_cs;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              cpu_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_q;

    // State register and record of the most recently served port
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_HOST;
        end else begin
            state_q <= state_d;
            if (state_q == CPU_ACC) begin
                last_owner_q <= OWN_CPU;
            end else if (state_q == HOST_ACC) begin
                last_owner_q <= OWN_HOST;
            end
        end
    end

    // Next-state selection and RAM / grant drive for the current owner
    always_comb begin
        state_d   = IDLE;
        cpu_gnt   = 1'b0;
        host_gnt  = 1'b0;
        mem_cs    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req && bus.host_req) begin
                    state_d = (last_owner_q == OWN_CPU) ? HOST_ACC : CPU_ACC;
                end else if (bus.cpu_req) begin
                    state_d = CPU_ACC;
                end else if (bus.host_req) begin
                    state_d = HOST_ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_ACC: begin
                cpu_gnt   = 1'b1;
                mem_cs    = 1'b1;
                mem_rd    = ~bus.cpu_we;
                mem_addr  = bus.cpu_addr;
                mem_wdata = bus.cpu_wdata;
                // cpu_req here is the request being completed, so only the
                // host can take the next cycle.
                state_d   = bus.host_req ? HOST_ACC : IDLE;
            end
            HOST_ACC: begin
                host_gnt  = 1'b1;
                mem_cs    = 1'b1;
                mem_rd    = ~bus.host_we;
                mem_addr  = bus.host_addr;
                mem_wdata = bus.host_wdata;
                state_d   = bus.cpu_req ? CPU_ACC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-port read return: capture RAM data at the closing edge of a read.
    // clr wins, so an access cut short by reset returns nothing.
    always_ff @(posedge clk) begin
        if (clr) begin
            cpu_rvalid_q  <= 1'b0;
            cpu_rdata_q   <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q  <= (state_q == CPU_ACC) && !bus.cpu_we;
            host_rvalid_q <= (state_q == HOST_ACC) && !bus.host_we;
            if ((state_q == CPU_ACC) && !bus.cpu_we) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
            if ((state_q == HOST_ACC) && !bus.host_we) begin
                host_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.host_gnt    = host_gnt;
    assign bus.cpu_stall   = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rvalid  = cpu_rvalid_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.mem_cs      = mem_cs;
    assign bus.mem_rd      = mem_rd;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural RAM.
// Inputs change 1 ns after each rising edge. Outputs are checked 1 ns later.
module tb_dm_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk;
    logic clr;
    logic ram_init;
    int   n_cmp;
    int   n_err;

    dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write at the edge that closes the access
    logic [DATA_W-1:0] ram [256];
    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (ram_init) begin
            ram[8'h10] <= 32'hDEAD_BEEF;
            ram[8'h20] <= 32'hCAFE_F00D;
        end else if (bus.mem_cs && !bus.mem_rd) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the grant invariants for the new cycle
    task automatic cyc();
        @(posedge clk);
        #1;
        chk("gnt_exclusive", 64'(bus.cpu_gnt & bus.host_gnt), 64'd0);
        chk("cs_iff_gnt", 64'(bus.mem_cs), 64'(bus.cpu_gnt | bus.host_gnt));
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        clr            = 1'b1;
        ram_init       = 1'b1;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;

        cyc();
        cyc();
        ram_init = 1'b0;
        clr      = 1'b0;
        #1;
        // Reset state
        chk("rst_cs",          64'(bus.mem_cs),      64'd0);
        chk("rst_cpu_gnt",     64'(bus.cpu_gnt),     64'd0);
        chk("rst_host_gnt",    64'(bus.host_gnt),    64'd0);
        chk("rst_cpu_rvalid",  64'(bus.cpu_rvalid),  64'd0);
        chk("rst_host_rvalid", 64'(bus.host_rvalid), 64'd0);
        chk("rst_cpu_rdata",   64'(bus.cpu_rdata),   64'd0);
        chk("rst_host_rdata",  64'(bus.host_rdata),  64'd0);

        // CPU read alone
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h10;
        #1;
        chk("rd_c0_gnt",   64'(bus.cpu_gnt),   64'd0);
        chk("rd_c0_stall", 64'(bus.cpu_stall), 64'd1);
        cyc();
        chk("rd_c1_gnt",   64'(bus.cpu_gnt),   64'd1);
        chk("rd_c1_stall", 64'(bus.cpu_stall), 64'd0);
        chk("rd_c1_rd",    64'(bus.mem_rd),    64'd1);
        chk("rd_c1_addr",  64'(bus.mem_addr),  64'h10);
        chk("rd_c1_hgnt",  64'(bus.host_gnt),  64'd0);
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        chk("rd_c2_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        chk("rd_c2_rdata",  64'(bus.cpu_rdata),  64'hDEAD_BEEF);
        chk("rd_c2_idle",   64'(bus.mem_cs),     64'd0);
        cyc();
        chk("rd_c3_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        chk("rd_c3_hold",   64'(bus.cpu_rdata),  64'hDEAD_BEEF);

        // Tie in the first cycle after reset: CPU first, then host
        clr = 1'b1;
        cyc();
        clr           = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 8'h10;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 8'h20;
        #1;
        chk("tie_rst_rdata", 64'(bus.cpu_rdata), 64'd0);
        chk("tie_c0_cs",     64'(bus.mem_cs),    64'd0);
        cyc();
        chk("tie_c1_cgnt", 64'(bus.cpu_gnt),  64'd1);
        chk("tie_c1_hgnt", 64'(bus.host_gnt), 64'd0);
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        chk("tie_c2_hgnt",   64'(bus.host_gnt),   64'd1);
        chk("tie_c2_addr",   64'(bus.mem_addr),   64'h20);
        chk("tie_c2_crv",    64'(bus.cpu_rvalid), 64'd1);
        chk("tie_c2_crdata", 64'(bus.cpu_rdata),  64'hDEAD_BEEF);
        cyc();
        bus.host_req = 1'b0;
        #1;
        chk("tie_c3_hrv",    64'(bus.host_rvalid), 64'd1);
        chk("tie_c3_hrdata", 64'(bus.host_rdata),  64'hCAFE_F00D);
        chk("tie_c3_cs",     64'(bus.mem_cs),      64'd0);
        cyc();

        // Sustained contention: grants alternate once the first one is issued
        bus.cpu_req  = 1'b1;
        bus.host_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("cont_cgnt",  64'(bus.cpu_gnt),   64'((i > 0) && (i % 2 == 1)));
            chk("cont_hgnt",  64'(bus.host_gnt),  64'((i > 0) && (i % 2 == 0)));
            chk("cont_cs",    64'(bus.mem_cs),    64'(i > 0));
            chk("cont_stall", 64'(bus.cpu_stall), 64'(!((i > 0) && (i % 2 == 1))));
            cyc();
        end
        bus.cpu_req  = 1'b0;
        bus.host_req = 1'b0;
        #1;
        chk("cont_last_hgnt", 64'(bus.host_gnt), 64'd1);
        cyc();
        chk("cont_end_cs",  64'(bus.mem_cs),      64'd0);
        chk("cont_end_hrv", 64'(bus.host_rvalid), 64'd1);
        cyc();

        // Host write, then CPU reads it back
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 8'h05;
        bus.host_wdata = 32'h1234_5678;
        #1;
        chk("wr_c0_hgnt", 64'(bus.host_gnt), 64'd0);
        cyc();
        chk("wr_c1_hgnt",  64'(bus.host_gnt),  64'd1);
        chk("wr_c1_rd",    64'(bus.mem_rd),    64'd0);
        chk("wr_c1_addr",  64'(bus.mem_addr),  64'h05);
        chk("wr_c1_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
        cyc();
        bus.host_req = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h05;
        #1;
        chk("wr_c2_hrv", 64'(bus.host_rvalid), 64'd0);
        chk("wr_c2_cs",  64'(bus.mem_cs),      64'd0);
        cyc();
        chk("wr_c3_cgnt", 64'(bus.cpu_gnt), 64'd1);
        cyc();
        bus.cpu_req = 1'b0;
        #1;
        chk("wr_c4_crv",    64'(bus.cpu_rvalid),  64'd1);
        chk("wr_c4_crdata", 64'(bus.cpu_rdata),   64'h1234_5678);
        chk("wr_c4_hrv",    64'(bus.host_rvalid), 64'd0);

        // Reset lands on a CPU read access
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h10;
        cyc();
        clr = 1'b1;
        #1;
        chk("rst_acc_gnt",  64'(bus.cpu_gnt),  64'd1);
        chk("rst_acc_addr", 64'(bus.mem_addr), 64'h10);
        cyc();
        clr         = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        chk("rst_acc_crv",    64'(bus.cpu_rvalid), 64'd0);
        chk("rst_acc_crdata", 64'(bus.cpu_rdata),  64'd0);
        chk("rst_acc_idle",   64'(bus.mem_cs),     64'd0);

        // Single-port back-to-back: CPU served every other cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h10;
        cyc();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.cpu_req = 1'b0;
            #1;
            chk("b2b_cgnt", 64'(bus.cpu_gnt),    64'(i % 2 == 0));
            chk("b2b_crv",  64'(bus.cpu_rvalid), 64'(i % 2 == 1));
            cyc();
        end
        chk("b2b_end_cs", 64'(bus.mem_cs), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, data-memory word-address width.
REQ-002 Parameter: DATA_W, 32, data word width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-004 clk  in  1  system clock.
REQ-005 clr  in  1  synchronous active-high reset.
REQ-006 cpu_req / cpu_we  in  1/1  CPU access request; write (1) or read (0).
REQ-007 cpu_addr / cpu_wdata  in  ADDR_W/DATA_W  CPU word address; CPU write data.
REQ-008 cpu_gnt  out  1  CPU access performed this cycle.
REQ-009 cpu_rvalid / cpu_rdata  out  1/DATA_W  registered CPU read return.
REQ-010 cpu_stall  out  1  cpu_req & !cpu_gnt.
REQ-011 host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata  SHALL mirror REQ-006..REQ-009 for the debug/host port.
REQ-012 mem_cs / mem_rd  out  1/1  RAM chip select; read enable (also drives oe).
REQ-013 mem_addr / mem_wdata  out  ADDR_W/DATA_W  RAM address; RAM write data.
REQ-014 mem_rdata  in  DATA_W  RAM combinational read data.

Function
REQ-015 FSM states SHALL be IDLE, CPU_ACC and HOST_ACC; a register last_owner records the port most recently granted.
REQ-016 IDLE: mem_cs=0, both gnt=0, mem_addr/mem_wdata=0.
REQ-017 IDLE->CPU_ACC when cpu_req & !host_req; IDLE->HOST_ACC when host_req & !cpu_req; both requesting -> grant the port != last_owner; neither -> stay IDLE.
REQ-018 CPU_ACC: cpu_gnt=1 (combinational from state); mem_cs=1; mem_rd=!cpu_we; mem_addr=cpu_addr; mem_wdata=cpu_wdata; the RAM write completes at the closing edge.
REQ-019 HOST_ACC: the same as REQ-018 using host_* signals and host_gnt.
REQ-020 Each ACC state SHALL last exactly one cycle; last_owner is updated at its closing edge.
REQ-021 From CPU_ACC: next state SHALL be HOST_ACC if host_req, else IDLE; HOST_ACC is symmetric. A port's req seen while in its own ACC state is the completing request, never a new one.
REQ-022 Throughput: one access per port per 2 cycles; alternating ports SHALL sustain one access per cycle.
REQ-023 Read: at the closing edge of a read ACC cycle, mem_rdata SHALL be captured into that port's rdata register and its rvalid SHALL be 1 for exactly the next cycle.
REQ-024 Write: rvalid SHALL stay 0.
REQ-025 rdata registers SHALL hold their value until the next read completion for that port.
REQ-026 A requester SHALL hold req, we, addr and wdata stable until its gnt; the block does not latch requests.
REQ-027 cpu_gnt and host_gnt SHALL never be 1 in the same cycle; mem_cs=1 iff a gnt is 1.

Reset
REQ-028 clr=1 at an edge SHALL force state=IDLE, last_owner=HOST (CPU wins the first tie), rvalid=0 and rdata=0 for both ports, regardless of the current state.
REQ-029 The cycle after clr: mem_cs=0, both gnt=0. A request held through clr SHALL be granted per REQ-017 starting the first cycle after clr deasserts.
REQ-030 An access whose ACC cycle coincides with clr=1 SHALL still present its mem_* signals, but no rvalid SHALL follow.

Verification
REQ-031 CPU read alone: RAM[0x10]=0xDEADBEEF, cpu_req=1, we=0, addr=0x10 in IDLE -> cpu_gnt in cycle 1, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in cycle 2, state IDLE in cycle 2.
REQ-032 Tie after reset: both ports request a read in the first cycle after clr -> CPU granted first, HOST next cycle; host_rvalid one cycle after host_gnt; no cycle with both gnt.
REQ-033 Sustained contention: both req held high for 8 cycles with re-requests -> grants alternate C,H,C,H; mem_cs=1 in every cycle after the first; cpu_stall=1 exactly in non-CPU cycles.
REQ-034 Host write then CPU read: host writes 0x12345678 to 0x05, then CPU reads 0x05 -> cpu_rdata=0x12345678; host_rvalid stays 0.
REQ-035 Reset mid-access: clr asserted during CPU_ACC of a read -> no cpu_rvalid the next cycle; cpu_rdata=0; state IDLE.
REQ-036 Single-port back-to-back: cpu_req held for 6 cycles -> cpu_gnt pattern 1,0,1,0,1,0 (granted in every other cycle, IDLE between).
